// File: rtl/abuf_int_port_arbiter.sv
// abuf_int_port_arbiter
// Arbitrates the activation buffer's single internal port between the PISO
// write queue and the feature-loader read path. Reads normally win so that
// compute stays fed. A write wins on a same-address hazard or once it has
// lost maxWrWait cycles in a row. All memory-side signals are registered,
// and returning read data is qualified by a tag shift register.
module abuf_int_port_arbiter #(
  parameter int addrWidth    = 32,
  parameter int dataWidth    = 256,
  parameter int maxWrWait    = 4,  // 1..15
  parameter int memRdLatency = 1   // 1..3
) (
  input  logic                 clk,
  input  logic                 nrst,            // synchronous, active-high

  input  logic                 wr_valid_i,
  input  logic [addrWidth-1:0] wr_addr_i,
  input  logic [dataWidth-1:0] wr_data_i,
  output logic                 wr_ready_o,

  input  logic                 rd_valid_i,
  input  logic [addrWidth-1:0] rd_addr_i,
  output logic                 rd_ready_o,
  output logic [dataWidth-1:0] rd_data_o,
  output logic                 rd_data_valid_o,

  output logic                 mem_wr_en_o,
  output logic [addrWidth-1:0] mem_wr_addr_o,
  output logic [dataWidth-1:0] mem_wr_data_o,
  output logic                 mem_rd_en_o,
  output logic [addrWidth-1:0] mem_rd_addr_o,
  input  logic [dataWidth-1:0] mem_rd_data_i,

  output logic [15:0]          conflict_cnt_o,
  output logic                 busy_o
);

  // Read-return tag pipe: bit 0 is set the cycle after a read is accepted,
  // and bit STAGES lines up with valid data on mem_rd_data_i.
  localparam int STAGES = memRdLatency;

  localparam logic [3:0] WR_WAIT_MAX = 4'(maxWrWait);

  // Write request as registered onto the memory port.
  typedef struct packed {
    logic                 en;
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] data;
  } mem_wr_t;

  // Read request as registered onto the memory port.
  typedef struct packed {
    logic                 en;
    logic [addrWidth-1:0] addr;
  } mem_rd_t;

  logic          both_vld;
  logic          hazard;
  logic          starved;
  logic          grant_wr;
  logic          grant_rd;
  logic [3:0]    wr_wait_cnt;
  logic [STAGES:0] vld_pipe;
  mem_wr_t       mem_wr_q;
  mem_rd_t       mem_rd_q;

  // Grant selection. Write wins when it is alone, when it collides with the
  // read address (so the read sees the new data), or once it is starved.
  // Nothing is granted while reset is asserted.
  always_comb begin
    both_vld = wr_valid_i && rd_valid_i;
    hazard   = both_vld && (rd_addr_i == wr_addr_i);
    starved  = both_vld && (wr_wait_cnt >= WR_WAIT_MAX);
    grant_wr = !nrst && wr_valid_i && (!rd_valid_i || hazard || starved);
    grant_rd = !nrst && rd_valid_i && !grant_wr;
  end

  assign wr_ready_o = grant_wr;
  assign rd_ready_o = grant_rd;

  // Starvation counter: counts consecutive lost cycles of a pending write.
  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_wait_cnt <= '0;
    end else if (!wr_valid_i || grant_wr) begin
      wr_wait_cnt <= '0;
    end else if (wr_wait_cnt != 4'hF) begin
      wr_wait_cnt <= wr_wait_cnt + 4'd1;
    end
  end

  // Saturating count of cycles where both requesters contend.
  always_ff @(posedge clk) begin
    if (nrst) begin
      conflict_cnt_o <= '0;
    end else if (both_vld && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end

  // Memory write port register: enable follows the grant, addr/data hold
  // their last value when no write is granted.
  always_ff @(posedge clk) begin
    if (nrst) begin
      mem_wr_q <= '0;
    end else begin
      mem_wr_q.en <= grant_wr;
      if (grant_wr) begin
        mem_wr_q.addr <= wr_addr_i;
        mem_wr_q.data <= wr_data_i;
      end
    end
  end

  // Memory read port register: same hold behaviour as the write side.
  always_ff @(posedge clk) begin
    if (nrst) begin
      mem_rd_q <= '0;
    end else begin
      mem_rd_q.en <= grant_rd;
      if (grant_rd) begin
        mem_rd_q.addr <= rd_addr_i;
      end
    end
  end

  // Tag pipe for accepted reads; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (nrst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], grant_rd};
    end
  end

  assign mem_wr_en_o     = mem_wr_q.en;
  assign mem_wr_addr_o   = mem_wr_q.addr;
  assign mem_wr_data_o   = mem_wr_q.data;
  assign mem_rd_en_o     = mem_rd_q.en;
  assign mem_rd_addr_o   = mem_rd_q.addr;

  // Read data is a straight passthrough; the tag qualifies it.
  assign rd_data_o       = mem_rd_data_i;
  assign rd_data_valid_o = vld_pipe[STAGES];

  assign busy_o = wr_valid_i | rd_valid_i | (|vld_pipe);

endmodule

// File: doc/abuf_int_port_arbiter.md
# abuf_int_port_arbiter

Shares the activation buffer's internal port between two requesters: the PISO write queue (output-scaler results) and the feature-loader read path. Used when the internal port is a single read-or-write-per-cycle macro. Reads have priority so the compute pipeline stays fed. Writes win on a read-after-write address hazard or after a bounded starvation window. The block sits between the controller/write queue and the buffer, registers all memory-side signals and tags returning read data.

## Interface
- addrWidth, 32, address width of both requesters and memory
- dataWidth, 256, internal interface width
- maxWrWait, 4, consecutive cycles a pending write may lose before it is forced (1..15)
- memRdLatency, 1, cycles from mem_rd_en_o to valid mem_rd_data_i (1..3)

- clk  in  1  clock, rising edge
- nrst  in  1  reset; synchronous, active-high (1 = reset)
- wr_valid_i  in  1  write request valid
- wr_addr_i  in  addrWidth  write address
- wr_data_i  in  dataWidth  write data
- wr_ready_o  out  1  write accepted this cycle
- rd_valid_i  in  1  read request valid
- rd_addr_i  in  addrWidth  read address
- rd_ready_o  out  1  read accepted this cycle
- rd_data_o  out  dataWidth  returned read data
- rd_data_valid_o  out  1  rd_data_o valid, one pulse per accepted read
- mem_wr_en_o  out  1  registered memory write enable
- mem_wr_addr_o  out  addrWidth  registered write address
- mem_wr_data_o  out  dataWidth  registered write data
- mem_rd_en_o  out  1  registered memory read enable
- mem_rd_addr_o  out  addrWidth  registered read address
- mem_rd_data_i  in  dataWidth  memory read data
- conflict_cnt_o  out  16  saturating count of cycles with both requests valid
- busy_o  out  1  request pending or read in flight

## Operation
- Handshake: valid/ready per requester; a transfer occurs when valid && ready. A requester holds payload stable while valid && !ready. Ready is combinational from the current requests and state. At most one of wr_ready_o/rd_ready_o is high per cycle.
- Grant rules, evaluated in order:
  - Only one valid: grant it.
  - Both valid, rd_addr_i == wr_addr_i (hazard): grant write.
  - Both valid, wr_wait_cnt >= maxWrWait: grant write.
  - Otherwise grant read.
- wr_wait_cnt (4-bit): increments when wr_valid_i && !wr_ready_o. Clears on a write grant or when wr_valid_i is low. Saturates at 15.
- Memory side: a granted transfer registers to mem_* on the next edge. The enable for a non-granted type is 0 that cycle. Addr/data hold their last value when the enable is 0.
- Read return: a shift register of depth 1+memRdLatency tags each accepted read. rd_data_o = mem_rd_data_i (passthrough) when the tag emerges. rd_data_valid_o pulses 1 cycle per read, in order.
- conflict_cnt_o: +1 each cycle both valids are high; saturates at 0xFFFF. Cleared only by reset.
- busy_o = wr_valid_i | rd_valid_i | any tag in flight.
- Reset: mem_wr_en_o=0, mem_rd_en_o=0, mem addr/data=0, rd_data_valid_o=0, tag pipe cleared, wr_wait_cnt=0, conflict_cnt_o=0. rd_data_o follows mem_rd_data_i but is qualified by valid=0.
- Reset mid-operation: in-flight reads are dropped with no rd_data_valid_o pulse. Memory enables deassert on the edge where reset is sampled.

## Timing
- Accept at cycle T -> mem_*_en_o high in T+1.
- Read accepted at T -> rd_data_valid_o high in T+1+memRdLatency (T+2 by default).
- Sustained throughput: 1 transfer/cycle.
- Write starvation bound: under continuous non-hazard reads, a write is granted no later than cycle maxWrWait after wr_valid_i rises. It loses cycles 0..maxWrWait-1 and wins in cycle maxWrWait.
- Hazard case: write at T, read at T+1. The read sees the new data because the memory write completes before the read enable.

## Test plan
- Reset: hold nrst=1 for 2 cycles with both valids high -> all enables 0, both readies 0 after the sampled edge, conflict_cnt_o=0.
- Read-only stream: 8 reads to addresses 0..7, memRdLatency=1 -> rd_ready_o high all 8 cycles. mem_rd_en_o follows one cycle later. 8 rd_data_valid_o pulses, each 2 cycles after its accept, in order.
- Starvation: wr_valid_i and rd_valid_i held high from T0, with distinct addresses and maxWrWait=4 -> reads are granted in T0..T3 and the write in T4. conflict_cnt_o=5 at T5.
- Hazard: write addr 0x10 data 0xA5…, read addr 0x10 in the same cycle -> write granted first and read granted next cycle. Returned data is 0xA5….
- Reset mid-flight: accept a read, assert nrst in the next cycle -> no rd_data_valid_o pulse. busy_o=0 after reset once valids are low.
- Saturation: force 70000 conflict cycles -> conflict_cnt_o holds at 0xFFFF.
